// File: rtl/sd_bmp_loader_if.sv
// sd_bmp_loader_if
//   Groups the BMP loader's control handshake, the sd_ctrl_top read port and
//   the SDRAM write-FIFO port into one bundle.
//   master : the loader (drives read requests, pixel writes, status)
//   slave  : the surrounding system (drives start/img_sel and the SD read side)
//   Signals:
//     start/img_sel                   load request and slot number
//     rd_busy/sd_rd_val_en/_data      sd_ctrl_top read status and data words
//     rd_start_en/rd_sec_addr         sector read request
//     sdram_wr_en/_addr/_data         RGB565 pixel writes
//     busy/done/err                   loader status
interface sd_bmp_loader_if #(
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned ADDR_W = 24
);
    logic              start;
    logic [SEL_W-1:0]  img_sel;
    logic              rd_busy;
    logic              sd_rd_val_en;
    logic [15:0]       sd_rd_val_data;
    logic              rd_start_en;
    logic [31:0]       rd_sec_addr;
    logic              sdram_wr_en;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic [15:0]       sdram_wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, img_sel, rd_busy, sd_rd_val_en, sd_rd_val_data,
        output rd_start_en, rd_sec_addr, sdram_wr_en, sdram_wr_addr,
               sdram_wr_data, busy, done, err
    );

    modport slave (
        output start, img_sel, rd_busy, sd_rd_val_en, sd_rd_val_data,
        input  rd_start_en, rd_sec_addr, sdram_wr_en, sdram_wr_addr,
               sdram_wr_data, busy, done, err
    );
endinterface

// File: rtl/sd_bmp_loader.sv
// sd_bmp_loader
//   Streams a 24-bpp BMP from one of IMG_NUM SD-card slots, validates the
//   header, strips row padding, converts BGR888 to RGB565 and issues addressed
//   SDRAM writes so the frame lands top-down.
//   Ports:
//     clk  - SD/user clock
//     rst  - asynchronous reset, active high
//     bus  - sd_bmp_loader_if.master (control, SD read port, SDRAM write port)
module sd_bmp_loader #(
    parameter int unsigned IMG_W      = 1024,
    parameter int unsigned IMG_H      = 768,
    parameter int unsigned IMG_NUM    = 4,
    parameter int unsigned SEL_W      = 2,
    parameter logic [31:0] BASE_SEC   = 32'd16640,
    parameter int unsigned SEC_STRIDE = 4609,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic            clk,
    input  logic            rst,
    sd_bmp_loader_if.master bus
);
    localparam logic [31:0] TOTAL = 32'(IMG_W * IMG_H);
    localparam logic [1:0]  PAD   = 2'((4 - ((3 * IMG_W) % 4)) % 4);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_HI, S_XFER} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_ptr, r_byte, r_off, r_width, r_height;
    logic [31:0]       r_pix, r_col, r_row;
    logic [1:0]        r_pad, r_phase;
    logic [7:0]        r_b, r_g;
    logic              r_sig_ok, r_hdr_ok, r_topdown, r_err, r_busy, r_done;
    logic              r_rd_start, r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;

    logic              w_accept, w_consume, w_rd_start, w_all_done, w_hdr_good;
    logic [15:0]       w_bpp;
    logic [31:0]       w_pix, w_col, w_row, w_pos, w_line, w_lin;
    logic [1:0]        w_pad, w_phase;
    logic [7:0]        w_b, w_g, w_byte;
    logic              w_emit;
    logic [ADDR_W-1:0] w_waddr;
    logic [15:0]       w_wdata;

    assign w_accept  = (r_state == S_IDLE) && bus.start && (32'(bus.img_sel) < IMG_NUM);
    assign w_consume = (r_state == S_XFER) && bus.sd_rd_val_en;

    // Little-endian field: even byte position arrives in [15:8].
    assign w_bpp      = {bus.sd_rd_val_data[7:0], bus.sd_rd_val_data[15:8]};
    assign w_hdr_good = r_sig_ok && (r_off >= 32'd54) && (r_off[31:16] == 16'd0) &&
                        (r_width == IMG_W) &&
                        ((r_height == IMG_H) || (r_height == (32'd0 - IMG_H))) &&
                        (w_bpp == 16'd24);

    // Both bytes of a word are walked in order; a word can finish at most one
    // pixel since a pixel needs three bytes.
    always_comb begin
        w_pix   = r_pix;
        w_col   = r_col;
        w_row   = r_row;
        w_pad   = r_pad;
        w_phase = r_phase;
        w_b     = r_b;
        w_g     = r_g;
        w_emit  = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        w_byte  = '0;
        w_pos   = '0;
        w_line  = '0;
        w_lin   = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_byte = (i == 0) ? bus.sd_rd_val_data[15:8] : bus.sd_rd_val_data[7:0];
            w_pos  = r_byte + 32'(i);
            if (r_hdr_ok && (w_pos >= r_off) && (w_pix < TOTAL)) begin
                if (w_pad != 2'd0) begin
                    w_pad = w_pad - 2'd1;
                end else begin
                    case (w_phase)
                        2'd0: begin w_b = w_byte; w_phase = 2'd1; end
                        2'd1: begin w_g = w_byte; w_phase = 2'd2; end
                        default: begin
                            w_line  = r_topdown ? w_row : (IMG_H - 32'd1 - w_row);
                            w_lin   = w_line * IMG_W + w_col;
                            w_emit  = 1'b1;
                            w_waddr = w_lin[ADDR_W-1:0];
                            w_wdata = {w_byte[7:3], w_g[7:2], w_b[7:3]};
                            w_phase = 2'd0;
                            w_pix   = w_pix + 32'd1;
                            w_col   = w_col + 32'd1;
                            if (w_col == IMG_W) begin
                                w_col = '0;
                                w_row = w_row + 32'd1;
                                w_pad = PAD;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign w_all_done = ((w_consume ? w_pix : r_pix) == TOTAL);

    always_comb begin
        w_next     = r_state;
        w_rd_start = 1'b0;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_REQ;
            S_REQ:     if (!bus.rd_busy) begin
                           w_rd_start = 1'b1;
                           w_next     = S_WAIT_HI;
                       end
            S_WAIT_HI: if (bus.rd_busy) w_next = S_XFER;
            S_XFER:    if (!bus.rd_busy) w_next = (w_all_done || r_err) ? S_IDLE : S_REQ;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_byte     <= '0;
            r_off      <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_pix      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_pad      <= '0;
            r_phase    <= '0;
            r_b        <= '0;
            r_g        <= '0;
            r_sig_ok   <= 1'b0;
            r_hdr_ok   <= 1'b0;
            r_topdown  <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_start <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_next;
            r_rd_start <= w_rd_start;
            r_done     <= 1'b0;
            r_wr_en    <= 1'b0;
            if (w_accept) begin
                r_ptr    <= BASE_SEC + 32'(bus.img_sel) * SEC_STRIDE;
                r_byte   <= '0;
                r_off    <= '0;
                r_width  <= '0;
                r_height <= '0;
                r_pix    <= '0;
                r_col    <= '0;
                r_row    <= '0;
                r_pad    <= '0;
                r_phase  <= '0;
                r_sig_ok <= 1'b0;
                r_hdr_ok <= 1'b0;
                r_err    <= 1'b0;
                r_busy   <= 1'b1;
            end
            if ((r_state == S_XFER) && !bus.rd_busy) begin
                if (w_all_done) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else if (r_err) begin
                    r_busy <= 1'b0;
                end else begin
                    r_ptr <= r_ptr + 32'd1;
                end
            end
            if (w_consume) begin
                r_byte    <= r_byte + 32'd2;
                r_pix     <= w_pix;
                r_col     <= w_col;
                r_row     <= w_row;
                r_pad     <= w_pad;
                r_phase   <= w_phase;
                r_b       <= w_b;
                r_g       <= w_g;
                r_wr_en   <= w_emit;
                r_wr_addr <= w_waddr;
                r_wr_data <= w_wdata;
                case (r_byte)
                    32'd0:  r_sig_ok        <= (bus.sd_rd_val_data == 16'h424D);
                    32'd10: r_off[15:0]     <= w_bpp;
                    32'd12: r_off[31:16]    <= w_bpp;
                    32'd18: r_width[15:0]   <= w_bpp;
                    32'd20: r_width[31:16]  <= w_bpp;
                    32'd22: r_height[15:0]  <= w_bpp;
                    32'd24: r_height[31:16] <= w_bpp;
                    32'd28: begin
                        r_hdr_ok  <= w_hdr_good;
                        r_err     <= !w_hdr_good;
                        r_topdown <= r_height[31];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_start_en   = r_rd_start;
    assign bus.rd_sec_addr   = r_ptr;
    assign bus.sdram_wr_en   = r_wr_en;
    assign bus.sdram_wr_addr = r_wr_addr;
    assign bus.sdram_wr_data = r_wr_data;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
endmodule

// File: tb/tb_sd_bmp_loader.sv
// tb_sd_bmp_loader
//   Directed bench for sd_bmp_loader with a 5x3 image. An SD model serves
//   256 words per sector request from a byte image of the BMP file; expected
//   pixel writes are queued when a load is started and popped on sdram_wr_en.
module tb_sd_bmp_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    sd_bmp_loader_if #(.SEL_W(2), .ADDR_W(24)) bus ();

    sd_bmp_loader #(
        .IMG_W(5), .IMG_H(3), .IMG_NUM(4), .SEL_W(2),
        .BASE_SEC(32'd100), .SEC_STRIDE(8), .ADDR_W(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int n_wr   = 0;
    int n_done = 0;
    logic [7:0]  file_mem [0:1535];
    logic [31:0] file_base = 32'd0;
    logic [39:0] exp_q [$];
    logic [31:0] req_log [$];

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_b(input int unsigned idx);
        return 8'(32'h10 + idx * 8);
    endfunction
    function automatic logic [7:0] pix_g(input int unsigned idx);
        return 8'(32'h20 + idx * 4);
    endfunction
    function automatic logic [7:0] pix_r(input int unsigned idx);
        return 8'(32'hF8 - idx * 8);
    endfunction

    task automatic build_img(input logic [31:0] height, input logic [31:0] off, input logic [15:0] bpp);
        for (int i = 0; i < 1536; i++) file_mem[i] = 8'h00;
        file_mem[0]  = 8'h42;
        file_mem[1]  = 8'h4D;
        file_mem[10] = off[7:0];
        file_mem[11] = off[15:8];
        file_mem[12] = off[23:16];
        file_mem[13] = off[31:24];
        file_mem[14] = 8'd40;
        file_mem[18] = 8'd5;
        file_mem[22] = height[7:0];
        file_mem[23] = height[15:8];
        file_mem[24] = height[23:16];
        file_mem[25] = height[31:24];
        file_mem[26] = 8'd1;
        file_mem[28] = bpp[7:0];
        file_mem[29] = bpp[15:8];
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                int p;
                p = int'(off) + r * 16 + c * 3;
                file_mem[p]     = pix_b(r * 5 + c);
                file_mem[p + 1] = pix_g(r * 5 + c);
                file_mem[p + 2] = pix_r(r * 5 + c);
            end
            file_mem[int'(off) + r * 16 + 15] = 8'hEE;
        end
    endtask

    task automatic push_exp(input bit topdown);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                int unsigned idx, line;
                logic [7:0] b, g, rr;
                idx  = r * 5 + c;
                line = topdown ? r : 2 - r;
                b = pix_b(idx); g = pix_g(idx); rr = pix_r(idx);
                exp_q.push_back({24'(line * 5 + c), rr[7:3], g[7:2], b[7:3]});
            end
        end
    endtask

    function automatic logic [7:0] rdb(input int idx);
        if (idx < 0 || idx >= 1536) return 8'h00;
        return file_mem[idx];
    endfunction

    // SD card model: one sector of 256 words per rd_start_en pulse.
    initial begin
        logic [31:0] sec;
        int bidx;
        bus.rd_busy        = 1'b0;
        bus.sd_rd_val_en   = 1'b0;
        bus.sd_rd_val_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.rd_start_en === 1'b1) begin
                sec = bus.rd_sec_addr;
                req_log.push_back(sec);
                @(negedge clk);
                bus.rd_busy = 1'b1;
                @(negedge clk);
                for (int k = 0; k < 256; k++) begin
                    bidx = (int'(sec) - int'(file_base)) * 512 + 2 * k;
                    bus.sd_rd_val_en   = 1'b1;
                    bus.sd_rd_val_data = {rdb(bidx), rdb(bidx + 1)};
                    @(negedge clk);
                end
                bus.sd_rd_val_en = 1'b0;
                @(negedge clk);
                bus.rd_busy = 1'b0;
            end
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (bus.sdram_wr_en === 1'b1) begin
            logic [39:0] e;
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("wr_extra", 40'(bus.sdram_wr_en), 40'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 40'(bus.sdram_wr_addr), 40'(e[39:16]));
                chk("wr_data", 40'(bus.sdram_wr_data), 40'(e[15:0]));
            end
        end
        if (bus.done === 1'b1) begin
            n_done++;
            chk("busy_at_done", 40'(bus.busy), 40'd0);
        end
    end

    task automatic do_start(input logic [1:0] sel);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.img_sel = sel;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int cnt = 0;
        while (bus.busy !== 1'b0 && cnt < maxc) begin
            @(negedge clk);
            cnt++;
        end
        chk("busy_timeout", 40'(cnt < maxc), 40'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_logs();
        req_log.delete();
        n_wr   = 0;
        n_done = 0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.img_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  40'(bus.busy), 40'd0);
        chk("rst_done",  40'(bus.done), 40'd0);
        chk("rst_err",   40'(bus.err), 40'd0);
        chk("rst_wr",    40'(bus.sdram_wr_en), 40'd0);
        chk("rst_start", 40'(bus.rd_start_en), 40'd0);
        chk("rst_sec",   40'(bus.rd_sec_addr), 40'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Bottom-up, slot 2, OFF=54; a start while busy must be ignored.
        clear_logs();
        file_base = 32'd116;
        build_img(32'd3, 32'd54, 16'd24);
        push_exp(1'b0);
        do_start(2'd2);
        repeat (20) @(negedge clk);
        chk("A_busy", 40'(bus.busy), 40'd1);
        do_start(2'd3);
        wait_idle(3000);
        chk("A_nreq",  40'(req_log.size()), 40'd1);
        chk("A_sec",   40'(req_log[0]), 40'd116);
        chk("A_nwr",   40'(n_wr), 40'd15);
        chk("A_ndone", 40'(n_done), 40'd1);
        chk("A_err",   40'(bus.err), 40'd0);
        chk("A_left",  40'(exp_q.size()), 40'd0);

        // Top-down, slot 0, accepted right after a completed load.
        clear_logs();
        file_base = 32'd100;
        build_img(32'hFFFF_FFFD, 32'd54, 16'd24);
        push_exp(1'b1);
        do_start(2'd0);
        wait_idle(3000);
        chk("B_nreq",  40'(req_log.size()), 40'd1);
        chk("B_sec",   40'(req_log[0]), 40'd100);
        chk("B_nwr",   40'(n_wr), 40'd15);
        chk("B_ndone", 40'(n_done), 40'd1);
        chk("B_left",  40'(exp_q.size()), 40'd0);

        // bpp 32 rejected.
        clear_logs();
        file_base = 32'd108;
        build_img(32'd3, 32'd54, 16'd32);
        do_start(2'd1);
        wait_idle(3000);
        chk("C_err",   40'(bus.err), 40'd1);
        chk("C_nwr",   40'(n_wr), 40'd0);
        chk("C_ndone", 40'(n_done), 40'd0);
        chk("C_nreq",  40'(req_log.size()), 40'd1);
        chk("C_sec",   40'(req_log[0]), 40'd108);
        chk("C_busy",  40'(bus.busy), 40'd0);

        // OFF=600: pixels only in the second sector; err cleared by new start.
        clear_logs();
        file_base = 32'd116;
        build_img(32'd3, 32'd600, 16'd24);
        push_exp(1'b0);
        do_start(2'd2);
        repeat (3) @(negedge clk);
        chk("D_err_clr", 40'(bus.err), 40'd0);
        wait_idle(3000);
        chk("D_nreq",  40'(req_log.size()), 40'd2);
        chk("D_sec0",  40'(req_log[0]), 40'd116);
        chk("D_sec1",  40'(req_log[1]), 40'd117);
        chk("D_nwr",   40'(n_wr), 40'd15);
        chk("D_ndone", 40'(n_done), 40'd1);
        chk("D_left",  40'(exp_q.size()), 40'd0);

        // Reset mid-XFER of the second sector while the SD model keeps streaming.
        clear_logs();
        file_base = 32'd108;
        build_img(32'd3, 32'd600, 16'd24);
        do_start(2'd1);
        begin
            int cnt = 0;
            while (!(req_log.size() == 2 && bus.rd_busy === 1'b1) && cnt < 3000) begin
                @(negedge clk);
                cnt++;
            end
            chk("E_req2_timeout", 40'(cnt < 3000), 40'd1);
        end
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("E_busy",  40'(bus.busy), 40'd0);
        chk("E_start", 40'(bus.rd_start_en), 40'd0);
        chk("E_sec",   40'(bus.rd_sec_addr), 40'd0);
        chk("E_wr",    40'(bus.sdram_wr_en), 40'd0);
        chk("E_err",   40'(bus.err), 40'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        begin
            int cnt = 0;
            while (bus.rd_busy !== 1'b0 && cnt < 1000) begin
                @(negedge clk);
                cnt++;
            end
            chk("E_sd_timeout", 40'(cnt < 1000), 40'd1);
        end
        repeat (4) @(negedge clk);
        chk("E_nwr",  40'(n_wr), 40'd0);
        chk("E_idle", 40'(bus.busy), 40'd0);

        // Fresh load from slot 0 after the abort.
        clear_logs();
        file_base = 32'd100;
        build_img(32'd3, 32'd54, 16'd24);
        push_exp(1'b0);
        do_start(2'd0);
        wait_idle(3000);
        chk("F_nreq",  40'(req_log.size()), 40'd1);
        chk("F_sec",   40'(req_log[0]), 40'd100);
        chk("F_nwr",   40'(n_wr), 40'd15);
        chk("F_ndone", 40'(n_done), 40'd1);
        chk("F_left",  40'(exp_q.size()), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
